mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store initiator for the byte-addressed, big-endian 4096-byte data memory. It accepts one load or store request at a time from the MEM pipeline stage over a valid/ready handshake. It drives the memory's address, write data, read/write strobes and 3-bit access mode, then captures the load result and returns it, or a fault, on a valid/ready response channel. It also keeps saturating load, store and fault counters for debug.

## Interface
- MEM_BYTES, 4096, memory size in bytes; the last legal byte address is MEM_BYTES-1.
- CNT_W, 16, width of each statistics counter.
- clk  in  1  clock; reset: reset, asynchronous, active-high; clock clk.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_op  in  3  000 W, 001 H signed, 010 HU, 011 B signed, 100 BU; stores allow only 000/001/011.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the least-significant bytes are used for H/B.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load data, already extended by memory; 0 for stores and faults.
- resp_fault  out  1  request was rejected (illegal op, range, or misalignment).
- mem_address  out  32  to memory.
- mem_write_data  out  32  to memory.
- mem_memread  out  1  to memory.
- mem_memwrite  out  1  to memory.
- mem_mode  out  3  to memory.
- mem_read_data  in  32  from memory; combinational, X when mem_memread is low.
- load_cnt, store_cnt, fault_cnt  out  CNT_W each  saturating counters.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on req_valid & req_ready, register all req_* fields.
  - Compute size: 4 bytes for op 000; 2 bytes for 001/010; 1 byte for 011/100.
  - Fault if op > 100.
  - Fault if req_store is set and op is 010 or 100.
  - Fault if addr + size - 1 > MEM_BYTES-1. Compute in 33 bits, so wrap is a fault.
  - Faulting requests go directly to RESP with resp_fault = 1. Otherwise go to ACCESS.
- ACCESS lasts exactly one cycle.
  - mem_address = addr; mem_mode = op; mem_write_data = wdata.
  - For a load, mem_memread = 1. mem_read_data is captured into resp_rdata at the closing clock edge.
  - For a store, mem_memwrite = 1. The memory writes at that same edge.
  - Next state is RESP.
- RESP: resp_valid = 1. Remain in RESP until resp_ready is sampled high, then go to IDLE.
- mem_memread and mem_memwrite are 0 outside ACCESS and are never both 1.
- mem_address, mem_write_data and mem_mode hold their last values outside ACCESS.
- Counters:
  - On entering RESP, increment exactly one of: fault_cnt for faults, store_cnt for stores, or load_cnt for loads.
  - Each counter saturates at 2^CNT_W-1.
- Reset, asynchronous at any time:
  - state = IDLE.
  - All mem_* outputs = 0.
  - resp_valid = 0, resp_fault = 0, resp_rdata = 0.
  - All counters = 0.
  - An in-flight store whose ACCESS edge coincides with reset is dropped, because the memory clears anyway.

## Timing
- req_ready = (state == IDLE) & ~reset. It is 0 while reset is asserted and 1 in the first cycle after release.
- Accept at edge T. Then ACCESS spans T to T+1, and resp_valid is high starting at T+1.
- Normal latency is 2 edges from acceptance to response. A fault responds after 1 edge.
- Back-to-back throughput: one request per 3 cycles when resp_ready is held high, and one per 2 cycles for faults.
- resp_rdata and resp_fault are stable while resp_valid is high and resp_ready is low.
- A request presented while not IDLE is not accepted. The requester must hold the request until it sees ready.

## Configuration
- LSU_ALIGN_CHECK_EN
  - Defined: an additional fault is raised for a misaligned access, which is a word access with addr[1:0] != 0 or a halfword access with addr[0] != 0. The access goes to RESP with resp_fault = 1, and no memory strobe is issued.
  - Undefined: misaligned accesses proceed to memory unchanged. Only the op and range checks apply.

## Test plan
- SW with addr 0x10 and wdata 0xDEADBEEF, then LW from 0x10:
  - The store response is fault 0 with rdata 0.
  - The load response gives rdata 0xDEADBEEF.
  - store_cnt = 1 and load_cnt = 1.
- With bytes 0x10..0x13 = DE AD BE EF:
  - LH 0x10 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000DEAD.
  - LB 0x13 -> 0xFFFFFFEF.
  - LBU 0x13 -> 0x000000EF.
- SB to 0x11 with wdata 0x12345677, then LW 0x10 -> 0xDE77BEEF.
- Range and op faults:
  - LW 0xFFD -> fault 1, with no mem_memread pulse.
  - Store with op 010 -> fault 1.
  - LB 0xFFF -> succeeds.
- Hold resp_ready at 0 for 5 cycles: resp_valid and resp_rdata stay stable, and req_ready stays 0. Then assert resp_ready: the FSM returns to IDLE on the next edge.
- Assert reset during ACCESS of an SW: all outputs take their reset values immediately, and after release req_ready = 1.
  - With LSU_ALIGN_CHECK_EN defined: LW 0x12 -> fault 1.
  - Without it: LW 0x12 -> fault 0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for the 4096-byte big-endian data memory.
// Optional misalignment fault is enabled by defining LSU_ALIGN_CHECK_EN.
module mem_lsu #(
    parameter int MEM_BYTES = 4096,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_fault,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [2:0]       mem_mode,
    input  logic [31:0]      mem_read_data,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);

    state_t      state;
    logic [2:0]  size_m1;
    logic [32:0] last_byte;
    logic        op_bad;
    logic        range_bad;
    logic        align_bad;
    logic        req_fault;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Legality of the request on the input bus; the end address is formed in
    // 33 bits so an access that wraps past 0xFFFFFFFF is caught as out of range.
    always_comb begin
        size_m1 = 3'd0;
        case (req_op)
            3'b000:         size_m1 = 3'd3;
            3'b001, 3'b010: size_m1 = 3'd1;
            default:        size_m1 = 3'd0;
        endcase
        op_bad    = (req_op > 3'd4) |
                    (req_store & ((req_op == 3'b010) | (req_op == 3'b100)));
        last_byte = {1'b0, req_addr} + {30'd0, size_m1};
        range_bad = last_byte > LAST_ADDR;
`ifdef LSU_ALIGN_CHECK_EN
        align_bad = ((req_op == 3'b000) & (req_addr[1:0] != 2'b00)) |
                    (((req_op == 3'b001) | (req_op == 3'b010)) & req_addr[0]);
`else
        align_bad = 1'b0;
`endif
        req_fault = op_bad | range_bad | align_bad;
    end

    assign req_ready = (state == IDLE) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_mode       <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            resp_valid     <= 1'b0;
            resp_fault     <= 1'b0;
            resp_rdata     <= '0;
            load_cnt       <= '0;
            store_cnt      <= '0;
            fault_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                            fault_cnt  <= sat_inc(fault_cnt);
                        end else begin
                            state          <= ACCESS;
                            mem_address    <= req_addr;
                            mem_mode       <= req_op;
                            mem_write_data <= req_wdata;
                            mem_memread    <= ~req_store;
                            mem_memwrite   <= req_store;
                        end
                    end
                end
                ACCESS: begin
                    // mem_memwrite still marks whether this access is a store
                    state        <= RESP;
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_fault   <= 1'b0;
                    if (mem_memwrite) begin
                        resp_rdata <= '0;
                        store_cnt  <= sat_inc(store_cnt);
                    end else begin
                        resp_rdata <= mem_read_data;
                        load_cnt   <= sat_inc(load_cnt);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven, scoreboarded bench for mem_lsu with a big-endian
// memory model; expectations follow LSU_ALIGN_CHECK_EN when it is defined.
module tb_mem_lsu;

    localparam int MEM_BYTES = 4096;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready, req_store;
    logic [2:0]       req_op;
    logic [31:0]      req_addr, req_wdata;
    logic             resp_valid, resp_ready, resp_fault;
    logic [31:0]      resp_rdata;
    logic [31:0]      mem_address, mem_write_data, mem_read_data;
    logic             mem_memread, mem_memwrite;
    logic [2:0]       mem_mode;
    logic [CNT_W-1:0] load_cnt, store_cnt, fault_cnt;

    mem_lsu #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_mode(mem_mode), .mem_read_data(mem_read_data),
        .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // Big-endian memory: combinational read, write at the clock edge, cleared by reset
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] b0, b1, b2, b3;
    assign b0 = mem[mem_address[11:0]];
    assign b1 = mem[mem_address[11:0] + 12'd1];
    assign b2 = mem[mem_address[11:0] + 12'd2];
    assign b3 = mem[mem_address[11:0] + 12'd3];

    always_comb begin
        mem_read_data = 'x;
        if (mem_memread) begin
            case (mem_mode)
                3'b000:  mem_read_data = {b0, b1, b2, b3};
                3'b001:  mem_read_data = {{16{b0[7]}}, b0, b1};
                3'b010:  mem_read_data = {16'h0000, b0, b1};
                3'b011:  mem_read_data = {{24{b0[7]}}, b0};
                3'b100:  mem_read_data = {24'h000000, b0};
                default: mem_read_data = 'x;
            endcase
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (mem_memwrite) begin
            case (mem_mode)
                3'b000: begin
                    mem[mem_address[11:0]]         <= mem_write_data[31:24];
                    mem[mem_address[11:0] + 12'd1] <= mem_write_data[23:16];
                    mem[mem_address[11:0] + 12'd2] <= mem_write_data[15:8];
                    mem[mem_address[11:0] + 12'd3] <= mem_write_data[7:0];
                end
                3'b001: begin
                    mem[mem_address[11:0]]         <= mem_write_data[15:8];
                    mem[mem_address[11:0] + 12'd1] <= mem_write_data[7:0];
                end
                3'b011:  mem[mem_address[11:0]] <= mem_write_data[7:0];
                default: ;
            endcase
        end
    end

    int rd_pulses = 0;
    int wr_pulses = 0;
    int both_cnt  = 0;
    always @(negedge clk) begin
        if (mem_memread)  rd_pulses++;
        if (mem_memwrite) wr_pulses++;
        if (mem_memread && mem_memwrite) both_cnt++;
    end

    typedef struct {
        logic        store;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_loads = 0, exp_stores = 0, exp_faults = 0;

    function automatic void add(input logic st, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] w, input logic f, input logic [31:0] r);
        vec_t v;
        v.store = st; v.op = op; v.addr = a; v.wdata = w; v.fault = f; v.rdata = r;
        tbl.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Issue one request, then pop its expectation when the response shows up
    task automatic applyStimulus(input vec_t v, input int hold);
        exp_t e;
        int   n, lat, rd0, wr0;
        e.fault = v.fault;
        e.rdata = v.rdata;
        e.lat   = v.fault ? 1 : 2;
        e.rd    = (!v.fault && !v.store) ? 1 : 0;
        e.wr    = (!v.fault && v.store) ? 1 : 0;
        sb.push_back(e);
        if (v.fault) exp_faults++;
        else if (v.store) exp_stores++;
        else exp_loads++;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_store = v.store; req_op = v.op;
        req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            timeoutFail("req_ready");
            req_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        n = 0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; lat++; n++; end
        if (!resp_valid) begin
            timeoutFail("resp_valid");
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checkOutput("resp_fault", 32'(resp_fault), 32'(e.fault));
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("latency", 32'(lat), 32'(e.lat));
        checkOutput("memread_pulses", 32'(rd_pulses - rd0), 32'(e.rd));
        checkOutput("memwrite_pulses", 32'(wr_pulses - wr0), 32'(e.wr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_resp_rdata", resp_rdata, e.rdata);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checkOutput("post_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_mem_address"}, mem_address, 32'd0);
        checkOutput({tag, "_mem_write_data"}, mem_write_data, 32'd0);
        checkOutput({tag, "_mem_mode"}, 32'(mem_mode), 32'd0);
        checkOutput({tag, "_mem_memread"}, 32'(mem_memread), 32'd0);
        checkOutput({tag, "_mem_memwrite"}, 32'(mem_memwrite), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        checkOutput({tag, "_load_cnt"}, 32'(load_cnt), 32'd0);
        checkOutput({tag, "_store_cnt"}, 32'(store_cnt), 32'd0);
        checkOutput({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   n;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_op = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

        add(1, 3'b000, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        add(0, 3'b000, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        add(0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFFDEAD);
        add(0, 3'b010, 32'h10, 32'h0, 0, 32'h0000DEAD);
        add(0, 3'b011, 32'h13, 32'h0, 0, 32'hFFFFFFEF);
        add(0, 3'b100, 32'h13, 32'h0, 0, 32'h000000EF);
        add(1, 3'b011, 32'h11, 32'h12345677, 0, 32'h0);
        add(0, 3'b000, 32'h10, 32'h0, 0, 32'hDE77BEEF);
        add(0, 3'b000, 32'hFFD, 32'h0, 1, 32'h0);
        add(1, 3'b010, 32'h20, 32'h55555555, 1, 32'h0);
        add(0, 3'b101, 32'h0, 32'h0, 1, 32'h0);
        add(1, 3'b100, 32'h0, 32'h0, 1, 32'h0);
        add(1, 3'b011, 32'hFFF, 32'h00000080, 0, 32'h0);
        add(0, 3'b011, 32'hFFF, 32'h0, 0, 32'hFFFFFF80);
        add(0, 3'b000, 32'hFFC, 32'h0, 0, 32'h00000080);
        add(0, 3'b000, 32'hFFFFFFFF, 32'h0, 1, 32'h0);
        add(0, 3'b001, 32'hFFF, 32'h0, 1, 32'h0);
        add(1, 3'b001, 32'h20, 32'hABCD1234, 0, 32'h0);
        add(0, 3'b000, 32'h20, 32'h0, 0, 32'h12340000);
`ifdef LSU_ALIGN_CHECK_EN
        add(0, 3'b000, 32'h12, 32'h0, 1, 32'h0);
        add(0, 3'b001, 32'h11, 32'h0, 1, 32'h0);
        add(1, 3'b000, 32'h21, 32'hCAFEF00D, 1, 32'h0);
        add(0, 3'b000, 32'h20, 32'h0, 0, 32'h12340000);
`else
        add(0, 3'b000, 32'h12, 32'h0, 0, 32'hBEEF0000);
        add(0, 3'b001, 32'h11, 32'h0, 0, 32'h000077BE);
        add(1, 3'b000, 32'h21, 32'hCAFEF00D, 0, 32'h0);
        add(0, 3'b000, 32'h20, 32'h0, 0, 32'h12CAFEF0);
`endif
        add(0, 3'b111, 32'h4, 32'h0, 1, 32'h0);

        #12;
        checkResetValues("init");
        @(negedge clk);
        reset = 1'b0;
        #1 checkOutput("init_req_ready_release", 32'(req_ready), 32'd1);

        foreach (tbl[i]) applyStimulus(tbl[i], 0);

        checkOutput("load_cnt", 32'(load_cnt), 32'(exp_loads));
        checkOutput("store_cnt", 32'(store_cnt), 32'(exp_stores));
        checkOutput("fault_cnt", 32'(fault_cnt), 32'(exp_faults));

        // Backpressure: response held for 5 cycles must stay stable
        v.store = 0; v.op = 3'b000; v.addr = 32'h10; v.wdata = 32'h0;
        v.fault = 0; v.rdata = 32'hDE77BEEF;
        applyStimulus(v, 5);

        // Reset landing in the ACCESS cycle of a store drops the write
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_op = 3'b000;
        req_addr = 32'h40; req_wdata = 32'h11223344;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) timeoutFail("reset_test_req_ready");
        @(posedge clk);
        #1 req_valid = 1'b0;
        checkOutput("access_memwrite", 32'(mem_memwrite), 32'd1);
        checkOutput("access_address", mem_address, 32'h40);
        #2 reset = 1'b1;
        #1 checkResetValues("midreset");
        @(negedge clk);
        reset = 1'b0;
        #1 checkOutput("midreset_req_ready_release", 32'(req_ready), 32'd1);
        exp_loads = 0; exp_stores = 0; exp_faults = 0;

        v.store = 0; v.op = 3'b000; v.addr = 32'h40; v.wdata = 32'h0;
        v.fault = 0; v.rdata = 32'h0;
        applyStimulus(v, 0);
        checkOutput("post_reset_load_cnt", 32'(load_cnt), 32'(exp_loads));
        checkOutput("post_reset_store_cnt", 32'(store_cnt), 32'(exp_stores));
        checkOutput("both_strobes", 32'(both_cnt), 32'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
